wb_dma_fetch: RTL
=================

WB_DMA_FETCH -- requirements
Module: wb_dma_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning number of 32-bit FIFO entries (power of two, 4..32).
REQ-002 SHALL have port wb_clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port wb_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to begin a transfer.
REQ-005 SHALL have port abort, input, 1 bit: one-cycle request to terminate the current transfer.
REQ-006 SHALL have port base_adr, input, 24 bits: byte start address; bits [1:0] are ignored.
REQ-007 SHALL have port word_cnt, input, 16 bits: number of 32-bit words to fetch.
REQ-008 SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a transfer completes or an abort completes.
REQ-010 SHALL have the Wishbone initiator ports wb_adr out 24, wb_dat_i in 32, wb_sel out 4, wb_cti out 3, wb_stb out 1, wb_cyc out 1, wb_we out 1, wb_ack in 1.
REQ-011 SHALL have port fifo_rd, input, 1 bit: pop request from the consumer.
REQ-012 SHALL have port fifo_q, output, 32 bits: head entry, first-word-fall-through.
REQ-013 SHALL have port fifo_empty, output, 1 bit: FIFO holds no entries.
REQ-014 SHALL have port fifo_level, output, 6 bits: current FIFO occupancy.

Function
REQ-015 SHALL tie wb_we=0 and wb_sel=4'hF at all times; wb_adr[1:0] SHALL always be 0.
REQ-016 SHALL implement states IDLE, SINGLE, BURST0, BURST1, GAP and FINISH.
REQ-017 SHALL accept start only in IDLE; it latches base_adr and word_cnt, and busy rises on the next cycle.
REQ-018 SHALL go from IDLE to FINISH when start arrives with word_cnt=0, with no bus cycle issued.
REQ-019 SHALL choose a burst when remaining>=2, cur_adr[2]=0 and free slots>=2, where free = FIFO_DEPTH - level.
REQ-020 SHALL choose a single beat when it does not choose a burst, provided remaining>=1 and free>=1; otherwise it SHALL hold in its current state with cyc/stb low.
REQ-021 SHALL drive SINGLE as cyc=stb=1 and cti=3'b000; on ack it SHALL push wb_dat_i, add 4 to the address, decrement remaining, and go to GAP.
REQ-022 SHALL drive BURST0 as cyc=stb=1 and cti=3'b010; on ack it SHALL push the word, add 4 to the address, and go to BURST1 with cyc/stb held high.
REQ-023 SHALL drive BURST1 as cti=3'b111 with the incremented address; on ack it SHALL push the word, subtract 2 from remaining, and go to GAP.
REQ-024 SHALL hold cyc, stb and adr stable in SINGLE, BURST0 and BURST1 until ack, with no timeout.
REQ-025 SHALL keep cyc/stb low for exactly one cycle in GAP, then issue the next request, or enter FINISH if remaining=0.
REQ-026 SHALL, in FINISH, assert done for one cycle, drop busy on the following cycle, and return to IDLE.
REQ-027 SHALL, on abort in SINGLE, BURST0 or BURST1, latch a pending flag and complete the bus cycle including BURST1, then go via GAP to FINISH; data from the completed cycle is pushed.
REQ-028 SHALL treat abort in GAP or in a held state as going to FINISH next cycle; abort in IDLE or FINISH SHALL be ignored.
REQ-029 SHALL wrap the address modulo 2^24, so 24'hFFFFFC+4 = 24'h000000.
REQ-030 SHALL ignore wb_ack outside SINGLE, BURST0 and BURST1.
REQ-031 SHALL make the FIFO circular, with pointers wrapping at FIFO_DEPTH.
REQ-032 SHALL pop the FIFO on fifo_rd & ~fifo_empty; fifo_rd when empty SHALL have no effect.
REQ-033 SHALL allow a push and a pop in the same cycle, leaving the level unchanged; a push never occurs when full.
REQ-034 SHALL NOT let start or abort clear the FIFO; only reset does.

Reset
REQ-035 SHALL, on wb_rst high, go asynchronously to IDLE with wb_cyc=wb_stb=0, wb_cti=0, wb_adr=0, busy=0, done=0, fifo_level=0, fifo_empty=1 and the FIFO pointers at 0.
REQ-036 SHALL, on reset during a bus cycle, drop cyc/stb immediately and discard the in-flight data.

Verification
REQ-037 SHALL cover: base 24'h000100, cnt 4, responder acks each beat after 3 cycles -> two bursts at 100/104 then 108/10C, cti 010 then 111, one GAP between, FIFO holds 4 words, done pulses once.
REQ-038 SHALL cover: base 24'h000104, cnt 3 -> single at 104 (cti 000), then burst 108/10C, done after third push.
REQ-039 SHALL cover: cnt 20, FIFO_DEPTH 8, consumer idle -> fetch stalls with level=8 and cyc low; after 2 pops one burst resumes.
REQ-040 SHALL cover: abort asserted in BURST0 -> BURST1 still completes, level=2, done pulses, no further cycles.
REQ-041 SHALL cover: base 24'hFFFFF8, cnt 4 -> addresses FFFFF8, FFFFFC, 000000, 000004.
REQ-042 SHALL cover: wb_rst pulsed while stb is waiting on ack -> cyc/stb go to 0 asynchronously, level=0, busy=0.

Source files
------------

// File: rtl/wb_dma_fetch.sv
// wb_dma_fetch: Wishbone read-DMA fetch engine filling a first-word-fall-through FIFO
module wb_dma_fetch #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] base_adr,
  input  logic [15:0] word_cnt,
  output logic        busy,
  output logic        done,
  output logic [23:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic        wb_stb,
  output logic        wb_cyc,
  output logic        wb_we,
  input  logic        wb_ack,
  input  logic        fifo_rd,
  output logic [31:0] fifo_q,
  output logic        fifo_empty,
  output logic [5:0]  fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, SINGLE, BURST0, BURST1, GAP, FINISH} state_t;
  state_t state_q, state_d;
  logic [23:0] adr_q, adr_d;
  logic [15:0] rem_q, rem_d;
  logic abt_q, abt_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [5:0] lvl_q;
  logic [31:0] mem [FIFO_DEPTH];
  logic bus, push, pop, can_burst, can_single;
  logic [6:0] free;
  assign bus = state_q == SINGLE || state_q == BURST0 || state_q == BURST1;
  assign push = bus & wb_ack;
  assign pop = fifo_rd & (lvl_q != 6'd0);
  assign free = 7'(FIFO_DEPTH) - {1'b0, lvl_q};
  assign can_burst = rem_q >= 16'd2 && !adr_q[2] && free >= 7'd2;
  assign can_single = rem_q != 16'd0 && free != 7'd0;
  assign wb_cyc = bus;
  assign wb_stb = bus;
  assign wb_we = 1'b0;
  assign wb_sel = 4'hF;
  assign wb_adr = adr_q;
  assign wb_cti = state_q == BURST0 ? 3'b010 : state_q == BURST1 ? 3'b111 : 3'b000;
  assign busy = state_q != IDLE;
  assign done = state_q == FINISH;
  assign fifo_q = mem[rd_q];
  assign fifo_empty = lvl_q == 6'd0;
  assign fifo_level = lvl_q;
  // Next-state: GAP is also the decision point and the stall state while the FIFO lacks room
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    rem_d = rem_q;
    abt_d = abt_q;
    case (state_q)
      IDLE: if (start) begin
        adr_d = base_adr & 24'hFFFFFC;
        rem_d = word_cnt;
        abt_d = 1'b0;
        state_d = word_cnt == 16'd0 ? FINISH : GAP;
      end
      GAP: state_d = (abort || abt_q || rem_q == 16'd0) ? FINISH :
                     can_burst ? BURST0 : can_single ? SINGLE : GAP;
      SINGLE, BURST0, BURST1: begin
        abt_d = abt_q | abort;
        if (wb_ack) begin
          adr_d = adr_q + 24'd4;
          rem_d = state_q == SINGLE ? rem_q - 16'd1 : state_q == BURST1 ? rem_q - 16'd2 : rem_q;
          state_d = state_q == BURST0 ? BURST1 : GAP;
        end
      end
      FINISH: begin
        state_d = IDLE;
        abt_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Transfer control registers
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= IDLE;
      adr_q <= 24'd0;
      rem_q <= 16'd0;
      abt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      rem_q <= rem_d;
      abt_q <= abt_d;
    end
  end
  // FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= 6'd0;
    end else begin
      wr_q <= push ? wr_q + AW'(1) : wr_q;
      rd_q <= pop ? rd_q + AW'(1) : rd_q;
      lvl_q <= lvl_q + 6'(push) - 6'(pop);
    end
  end
  // FIFO storage needs no reset; occupancy alone defines validity
  always_ff @(posedge wb_clk) begin
    if (push) mem[wr_q] <= wb_dat_i;
  end
endmodule
